// File: rtl/store_align_issue.sv
// Store issue: align-check, lane-replicate and strobe one store, then run one write on the data SRAM bus.
// Accept->req 1 cycle, st_done the cycle after data_ok; st_ready only in IDLE, so one store in flight at a time.
module store_align_issue #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        flush,
  output logic        st_ready,
  output logic        st_done,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic        bus_err,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       badvaddr_q, badvaddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flushed_q, flushed_d;
  logic              st_done_q, st_done_d;
  logic              ades_q, ades_d;
  logic              bus_err_q, bus_err_d;

  logic        is_sb, is_sh, aligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [1:0]  lane_size;

  // Any st_type other than sb/sh is treated as sw.
  always_comb begin
    is_sb = (st_type == 3'b000);
    is_sh = (st_type == 3'b010);
    aligned    = 1'b1;
    lane_wdata = st_data;
    lane_wstrb = 4'b1111;
    lane_size  = 2'd2;
    if (is_sb) begin
      lane_wdata = {4{st_data[7:0]}};
      lane_wstrb = 4'b0001 << st_addr[1:0];
      lane_size  = 2'd0;
    end else if (is_sh) begin
      aligned    = ~st_addr[0];
      lane_wdata = {2{st_data[15:0]}};
      lane_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
      lane_size  = 2'd1;
    end else begin
      aligned    = (st_addr[1:0] == 2'b00);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    badvaddr_d = badvaddr_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    st_done_d  = 1'b0;
    ades_d     = 1'b0;
    bus_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        flushed_d = 1'b0;
        if (st_valid && !flush) begin
          if (aligned) begin
            state_d = S_REQ;
            addr_d  = st_addr;
            wdata_d = lane_wdata;
            wstrb_d = lane_wstrb;
            size_d  = lane_size;
          end else begin
            ades_d     = 1'b1;
            badvaddr_d = st_addr;
          end
        end
      end
      S_REQ: begin
        if (data_sram_addr_ok) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          flushed_d = flushed_q | flush;
        end else if (flush) begin
          state_d   = S_IDLE;
          flushed_d = 1'b0;
        end
      end
      S_WAIT: begin
        flushed_d = flushed_q | flush;
        if (data_sram_data_ok) begin
          // A flush arriving with data_ok still suppresses the completion.
          state_d   = S_IDLE;
          st_done_d = ~(flushed_q | flush);
          flushed_d = 1'b0;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          flushed_d = 1'b0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      badvaddr_q <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      st_done_q  <= 1'b0;
      ades_q     <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      badvaddr_q <= badvaddr_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
      st_done_q  <= st_done_d;
      ades_q     <= ades_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign st_ready        = (state_q == S_IDLE);
  assign st_done         = st_done_q;
  assign ades            = ades_q;
  assign badvaddr        = badvaddr_q;
  assign bus_err         = bus_err_q;
  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wr    = (state_q == S_REQ);
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;
  assign data_sram_wstrb = wstrb_q;

endmodule

// File: tb/tb_store_align_issue.sv
// Directed bench for store_align_issue: lane-mapping table plus flush, timeout and reset sequences.
module tb_store_align_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        flush;
  logic        st_ready, st_done, ades, bus_err;
  logic [31:0] badvaddr;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;

  int n_total = 0;
  int n_pass  = 0;

  store_align_issue #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .flush(flush), .st_ready(st_ready), .st_done(st_done), .ades(ades),
    .badvaddr(badvaddr), .bus_err(bus_err),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_ades;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_size;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_type = t; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b0, 32'hA5A5_A5A5, 4'b1000, 2'd0};
    vecs[1] = '{3'b010, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 32'hBEEF_BEEF, 4'b1100, 2'd1};
    vecs[2] = '{3'b100, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b1111, 2'd2};
    vecs[3] = '{3'b100, 32'h0000_2001, 32'h1111_1111, 1'b1, 32'h0,         4'b0000, 2'd0};
    vecs[4] = '{3'b010, 32'h0000_3001, 32'h2222_2222, 1'b1, 32'h0,         4'b0000, 2'd0};
    vecs[5] = '{3'b000, 32'h0000_1001, 32'h0000_0042, 1'b0, 32'h4242_4242, 4'b0010, 2'd0};
    vecs[6] = '{3'b010, 32'h0000_4000, 32'hFFFF_5A5A, 1'b0, 32'h5A5A_5A5A, 4'b0011, 2'd1};
    vecs[7] = '{3'b111, 32'h0000_0008, 32'h0102_0304, 1'b0, 32'h0102_0304, 4'b1111, 2'd2};
    vecs[8] = '{3'b111, 32'h0000_0006, 32'h0102_0304, 1'b1, 32'h0,         4'b0000, 2'd0};

    rst = 1'b1; st_valid = 1'b0; st_type = 3'b0; st_addr = '0; st_data = '0; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #12;
    chk("rst_req", {31'b0, data_sram_req}, 32'd0);
    chk("rst_wr", {31'b0, data_sram_wr}, 32'd0);
    chk("rst_wdata", data_sram_wdata, 32'd0);
    chk("rst_badvaddr", badvaddr, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_done", {29'b0, st_done, ades, bus_err}, 32'd0);

    // Table: each store runs accept -> REQ -> addr_ok -> data_ok back-to-back.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].typ, vecs[i].addr, vecs[i].data);
      if (vecs[i].exp_ades) begin
        chk($sformatf("v%0d_ades", i), {31'b0, ades}, 32'd1);
        chk($sformatf("v%0d_badvaddr", i), badvaddr, vecs[i].addr);
        chk($sformatf("v%0d_noreq", i), {31'b0, data_sram_req}, 32'd0);
        chk($sformatf("v%0d_ready", i), {31'b0, st_ready}, 32'd1);
        step();
        chk($sformatf("v%0d_ades_pulse", i), {31'b0, ades}, 32'd0);
      end else begin
        chk($sformatf("v%0d_req", i), {30'b0, data_sram_req, data_sram_wr}, 32'd3);
        chk($sformatf("v%0d_addr", i), data_sram_addr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), data_sram_wdata, vecs[i].exp_wdata);
        chk($sformatf("v%0d_wstrb", i), {28'b0, data_sram_wstrb}, {28'b0, vecs[i].exp_wstrb});
        chk($sformatf("v%0d_size", i), {30'b0, data_sram_size}, {30'b0, vecs[i].exp_size});
        chk($sformatf("v%0d_ready_busy", i), {31'b0, st_ready}, 32'd0);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        chk($sformatf("v%0d_req_drop", i), {31'b0, data_sram_req}, 32'd0);
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        chk($sformatf("v%0d_done", i), {30'b0, st_done, st_ready}, 32'd3);
        step();
        chk($sformatf("v%0d_done_pulse", i), {31'b0, st_done}, 32'd0);
      end
    end

    // sb with data_ok one cycle late: done lands at T+4.
    issue(3'b000, 32'h0000_1003, 32'h0000_00A5);
    data_sram_addr_ok = 1'b1; step(); data_sram_addr_ok = 1'b0;
    step();
    chk("late_no_done_yet", {31'b0, st_done}, 32'd0);
    data_sram_data_ok = 1'b1; step(); data_sram_data_ok = 1'b0;
    chk("late_done", {30'b0, st_done, st_ready}, 32'd3);

    // Store offered together with flush in IDLE is ignored.
    st_valid = 1'b1; flush = 1'b1; st_type = 3'b100; st_addr = 32'h40; st_data = 32'h5;
    step();
    st_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_noreq", {31'b0, data_sram_req}, 32'd0);

    // Flush in REQ without addr_ok drops the request.
    issue(3'b100, 32'h0000_0020, 32'hCAFE_F00D);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_req_drop", {30'b0, data_sram_req, st_ready}, 32'd1);
    step();
    chk("flush_req_nodone", {31'b0, st_done}, 32'd0);

    // Flush in WAIT: data_ok still retires the write, but silently.
    issue(3'b100, 32'h0000_0024, 32'hCAFE_F00D);
    data_sram_addr_ok = 1'b1; step(); data_sram_addr_ok = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_wait_busy", {31'b0, st_ready}, 32'd0);
    data_sram_data_ok = 1'b1; step(); data_sram_data_ok = 1'b0;
    chk("flush_wait_nodone", {30'b0, st_done, st_ready}, 32'd1);

    // Timeout: bus_err exactly 4 cycles after entering WAIT.
    issue(3'b100, 32'h0000_0030, 32'h0);
    data_sram_addr_ok = 1'b1; step(); data_sram_addr_ok = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("to_quiet%0d", k), {31'b0, bus_err}, 32'd0);
    end
    step();
    chk("to_bus_err", {29'b0, bus_err, st_done, st_ready}, 32'd5);
    step();
    chk("to_pulse", {31'b0, bus_err}, 32'd0);

    // data_ok on the timeout cycle wins.
    issue(3'b100, 32'h0000_0034, 32'h0);
    data_sram_addr_ok = 1'b1; step(); data_sram_addr_ok = 1'b0;
    step(); step(); step();
    data_sram_data_ok = 1'b1; step(); data_sram_data_ok = 1'b0;
    chk("to_race", {30'b0, st_done, bus_err}, 32'd2);

    // Reset mid-WAIT, then a stray data_ok.
    issue(3'b100, 32'h0000_0038, 32'h7777_7777);
    data_sram_addr_ok = 1'b1; step(); data_sram_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, st_ready}, 32'd1);
    chk("mid_rst_bus", data_sram_wdata | data_sram_addr | {26'b0, data_sram_wstrb, data_sram_size}, 32'd0);
    #3 rst = 1'b0;
    data_sram_data_ok = 1'b1; step(); data_sram_data_ok = 1'b0;
    chk("mid_rst_nodone", {29'b0, st_done, data_sram_req, st_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
